// File: rtl/title_scheduler_if.sv
// title_scheduler_if
//   Bundles the control, title-ROM and character-output signals of the
//   song-title overlay sequencer.
//   Ports (all logic):
//     load        1  one-cycle fetch request
//     song_sel    2  song index, sampled with load
//     frame_tick  1  one pulse per VGA frame (vertical blank)
//     rom_addr    7  {song, index[4:0]} toward the title ROM
//     rom_data    9  ROM read data, one cycle after rom_addr
//     char1..12   9  displayed character codes, left to right
//     busy        1  fetch in progress
//     scrolling   1  displayed title is longer than the 12-character window
//   Modports: master = environment (requester + ROM), slave = sequencer.
interface title_scheduler_if;
    logic       load;
    logic [1:0] song_sel;
    logic       frame_tick;
    logic [6:0] rom_addr;
    logic [8:0] rom_data;
    logic [8:0] char1, char2, char3, char4, char5, char6;
    logic [8:0] char7, char8, char9, char10, char11, char12;
    logic       busy;
    logic       scrolling;

    modport master (
        output load, song_sel, frame_tick, rom_data,
        input  rom_addr, busy, scrolling,
        input  char1, char2, char3, char4, char5, char6,
        input  char7, char8, char9, char10, char11, char12
    );

    modport slave (
        input  load, song_sel, frame_tick, rom_data,
        output rom_addr, busy, scrolling,
        output char1, char2, char3, char4, char5, char6,
        output char7, char8, char9, char10, char11, char12
    );
endinterface

// File: rtl/title_scheduler.sv
// title_scheduler
//   Fetches a song title (length word + MAX_LEN character codes) from the
//   title ROM into a local buffer and drives the 12 overlay characters.
//   Titles up to 12 characters are shown static and space-padded; longer
//   titles scroll left one character every SCROLL_FRAMES frames, with GAP
//   spaces between the end and the restart. Outputs only change on
//   frame_tick so a frame is never torn.
//   Ports:
//     clk    system (pixel-domain) clock
//     reset  synchronous, active-high
//     bus    title_scheduler_if.slave (load/song_sel/frame_tick in,
//            rom_addr out / rom_data in, char1..char12, busy, scrolling out)
module title_scheduler #(
    parameter int         MAX_LEN       = 24,
    parameter int         GAP           = 4,
    parameter int         SCROLL_FRAMES = 15,
    parameter logic [8:0] SPACE_CODE    = 9'h100
) (
    input logic              clk,
    input logic              reset,
    title_scheduler_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DISPLAY = 2'd2;
    localparam int         VIS        = 12;
    localparam logic [4:0] LAST_IDX   = 5'(MAX_LEN);
    localparam logic [4:0] LAST_FRAME = 5'(SCROLL_FRAMES - 1);

    logic [1:0] state;
    logic [1:0] song;
    logic [4:0] addr_idx;
    logic       issue_done;
    logic [4:0] cap_idx_p1;
    logic       cap_vld_p1;
    logic [4:0] len;
    logic [4:0] offset;
    logic [4:0] frame_cnt;
    logic [8:0] title_buf [MAX_LEN];
    logic [8:0] chars [VIS];
    logic [8:0] next_chars [VIS];
    logic [5:0] period;
    logic       is_scroll;

    // Saturate the raw ROM length word to the buffer depth.
    function automatic logic [4:0] clamp_len(input logic [8:0] raw);
        return (raw > 9'(MAX_LEN)) ? LAST_IDX : raw[4:0];
    endfunction

    assign period    = {1'b0, len} + 6'(GAP);
    assign is_scroll = (len > 5'(VIS));

    // Window contents for the next tick. For scrolling titles offset+k is
    // always below 2*period, so one conditional subtract is the modulo.
    always_comb begin : char_mux
        logic [5:0] pos;
        pos = '0;
        for (int k = 0; k < VIS; k++) begin
            next_chars[k] = SPACE_CODE;
            if (is_scroll) begin
                pos = {1'b0, offset} + 6'(k);
                if (pos >= period) pos = pos - period;
            end else begin
                pos = 6'(k);
            end
            if (pos < {1'b0, len}) next_chars[k] = title_buf[pos[4:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            song       <= '0;
            addr_idx   <= '0;
            issue_done <= 1'b0;
            cap_idx_p1 <= '0;
            cap_vld_p1 <= 1'b0;
            len        <= '0;
            offset     <= '0;
            frame_cnt  <= '0;
            for (int k = 0; k < MAX_LEN; k++) title_buf[k] <= SPACE_CODE;
            for (int k = 0; k < VIS; k++) chars[k] <= SPACE_CODE;
        end else if (bus.load) begin
            // A load in any state (also mid-fetch) restarts from index 0;
            // every buffer entry is rewritten, so stale data cannot survive.
            state      <= ST_FETCH;
            song       <= bus.song_sel;
            addr_idx   <= '0;
            issue_done <= 1'b0;
            cap_vld_p1 <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // --- stage p0: address issue, index 0..MAX_LEN ---
                    cap_vld_p1 <= !issue_done;
                    cap_idx_p1 <= addr_idx;
                    if (!issue_done) begin
                        if (addr_idx == LAST_IDX) issue_done <= 1'b1;
                        else                      addr_idx   <= addr_idx + 5'd1;
                    end
                    // --- stage p1: ROM data capture ---
                    if (cap_vld_p1) begin
                        if (cap_idx_p1 == 5'd0) len <= clamp_len(bus.rom_data);
                        else title_buf[cap_idx_p1 - 5'd1] <= bus.rom_data;
                        if (cap_idx_p1 == LAST_IDX) begin
                            state     <= ST_DISPLAY;
                            offset    <= '0;
                            frame_cnt <= '0;
                        end
                    end
                end
                ST_DISPLAY: begin
                    if (bus.frame_tick) begin
                        for (int k = 0; k < VIS; k++) chars[k] <= next_chars[k];
                        if (is_scroll) begin
                            if (frame_cnt == LAST_FRAME) begin
                                frame_cnt <= '0;
                                offset    <= ({1'b0, offset} + 6'd1 == period) ?
                                             5'd0 : offset + 5'd1;
                            end else begin
                                frame_cnt <= frame_cnt + 5'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr  = {song, addr_idx};
    assign bus.busy      = (state == ST_FETCH);
    assign bus.scrolling = (state == ST_DISPLAY) && is_scroll;

    assign bus.char1  = chars[0];
    assign bus.char2  = chars[1];
    assign bus.char3  = chars[2];
    assign bus.char4  = chars[3];
    assign bus.char5  = chars[4];
    assign bus.char6  = chars[5];
    assign bus.char7  = chars[6];
    assign bus.char8  = chars[7];
    assign bus.char9  = chars[8];
    assign bus.char10 = chars[9];
    assign bus.char11 = chars[10];
    assign bus.char12 = chars[11];
endmodule

// File: tb/tb_title_scheduler.sv
// tb_title_scheduler
//   Self-checking bench for title_scheduler: a title ROM model, directed
//   scenarios and a randomized phase, compared against a virtual-string
//   reference model driven by the number of frame ticks since display start.
module tb_title_scheduler;
    localparam int         SF   = 2;
    localparam int         MAXL = 24;
    localparam int         GAPN = 4;
    localparam logic [8:0] SP   = 9'h100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    title_scheduler_if tif ();

    title_scheduler #(
        .MAX_LEN(MAXL), .GAP(GAPN), .SCROLL_FRAMES(SF), .SPACE_CODE(SP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(tif)
    );

    // Title ROM: registered read, data one cycle after the address.
    logic [8:0] rom [128];
    always @(posedge clk) tif.rom_data <= rom[tif.rom_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [8:0] m_buf [MAXL];
    int         m_len;
    int         m_ticks;
    bit         m_disp;
    logic [8:0] m_exp [12];

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] get_char(input int k);
        case (k)
            0:  return tif.char1;
            1:  return tif.char2;
            2:  return tif.char3;
            3:  return tif.char4;
            4:  return tif.char5;
            5:  return tif.char6;
            6:  return tif.char7;
            7:  return tif.char8;
            8:  return tif.char9;
            9:  return tif.char10;
            10: return tif.char11;
            default: return tif.char12;
        endcase
    endfunction

    task automatic chk_chars(input string tag);
        for (int k = 0; k < 12; k++)
            chk($sformatf("%s_char%0d", tag, k + 1), get_char(k), m_exp[k]);
    endtask

    // Window = 12 characters of virt = title ++ GAP spaces, starting at
    // (ticks already seen / SF) mod period.
    function automatic void model_tick();
        logic [8:0] virt [$];
        int p, off;
        virt = {};
        for (int i = 0; i < m_len; i++) virt.push_back(m_buf[i]);
        if (m_len <= 12) begin
            for (int k = 0; k < 12; k++) m_exp[k] = (k < m_len) ? m_buf[k] : SP;
        end else begin
            for (int i = 0; i < GAPN; i++) virt.push_back(SP);
            off = (m_ticks / SF) % virt.size();
            for (int k = 0; k < 12; k++) begin
                p = (off + k) % virt.size();
                m_exp[k] = virt[p];
            end
        end
        m_ticks++;
    endfunction

    task automatic tick();
        tif.frame_tick = 1'b1;
        cyc();
        tif.frame_tick = 1'b0;
        if (m_disp) model_tick();
        chk_chars("tick");
    endtask

    // Issue load(song); optionally a frame_tick on the same cycle and a
    // second load(song2) reload_at cycles later. Checks busy length,
    // addresses, held outputs, then installs the new title in the model.
    task automatic fetch(input int song, input bit with_tick, input int reload_at, input int song2);
        int fs, busy_cnt, n, raw;
        fs = (reload_at > 0) ? song2 : song;
        tif.song_sel   = 2'(song);
        tif.load       = 1'b1;
        tif.frame_tick = with_tick;
        cyc();
        tif.load       = 1'b0;
        tif.frame_tick = 1'b0;
        tif.song_sel   = 2'($urandom);
        chk_chars("load_hold");
        busy_cnt = 0;
        n = 1;
        while (tif.busy === 1'b1 && n < 80) begin
            if (n == 1) chk("addr_first", tif.rom_addr, song * 32);
            if (n == reload_at + 25) chk("addr_last", tif.rom_addr, fs * 32 + 24);
            busy_cnt++;
            if (reload_at > 0 && n == reload_at) begin
                tif.load     = 1'b1;
                tif.song_sel = 2'(song2);
            end
            tif.frame_tick = ($urandom_range(0, 3) == 0);
            cyc();
            tif.load       = 1'b0;
            tif.frame_tick = 1'b0;
            n++;
        end
        chk("busy_len", busy_cnt, reload_at + 26);
        chk_chars("fetch_hold");
        raw   = int'(rom[fs * 32]);
        m_len = (raw > MAXL) ? MAXL : raw;
        for (int i = 0; i < MAXL; i++) m_buf[i] = rom[fs * 32 + 1 + i];
        m_ticks = 0;
        m_disp  = 1'b1;
        chk("scrolling", tif.scrolling, (m_len > 12));
    endtask

    task automatic fill_song(input int s, input int len_word);
        rom[s * 32] = 9'(len_word);
        for (int i = 1; i < 32; i++) rom[s * 32 + i] = 9'($urandom_range(0, 63) * 8);
    endtask

    logic [8:0] pink [12];
    logic [8:0] owl [3];

    initial begin
        pink = '{9'h080, 9'h048, 9'h070, 9'h058, 9'h100, 9'h080,
                 9'h008, 9'h070, 9'h0a0, 9'h040, 9'h028, 9'h090};
        owl  = '{9'h078, 9'h0b8, 9'h060};
        fill_song(0, 14);
        fill_song(1, 12);
        for (int i = 0; i < 12; i++) rom[32 + 1 + i] = pink[i];
        fill_song(2, 3);
        for (int i = 0; i < 3; i++) rom[64 + 1 + i] = owl[i];
        fill_song(3, 31);
        for (int k = 0; k < 12; k++) m_exp[k] = SP;
        m_disp = 1'b0; m_len = 0; m_ticks = 0;

        // Reset state
        reset = 1'b1; tif.load = 1'b0; tif.frame_tick = 1'b0; tif.song_sel = 2'd0;
        cyc(); cyc();
        reset = 1'b0;
        chk_chars("rst");
        chk("rst_busy", tif.busy, 0);
        chk("rst_scrolling", tif.scrolling, 0);
        chk("rst_addr", tif.rom_addr, 0);
        tick();  // IDLE ignores ticks

        // Reset mid-fetch
        tif.song_sel = 2'd1; tif.load = 1'b1;
        cyc();
        tif.load = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("midfetch_busy", tif.busy, 1);
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk_chars("rst2");
        chk("rst2_busy", tif.busy, 0);
        chk("rst2_addr", tif.rom_addr, 0);
        tick();
        chk("rst2_idle_busy", tif.busy, 0);

        // Static title "pink panther"
        fetch(1, 1'b0, 0, 0);
        tick();
        for (int k = 0; k < 12; k++) chk($sformatf("pink_char%0d", k + 1), get_char(k), pink[k]);
        tick();

        // Short title "owl"
        fetch(2, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("owl_char1", tif.char1, owl[0]);
        chk("owl_char4", tif.char4, SP);

        // Scrolling title, length 14, period 18
        fetch(0, 1'b0, 0, 0);
        for (int t = 0; t < 40; t++) begin
            tick();
            if (t < 2)   chk("scr_first_char1", tif.char1, rom[1]);
            if (t == 2)  chk("scr_step_char1", tif.char1, rom[2]);
            if (t == 6)  chk("scr_off3_char12", tif.char12, SP);
            if (t == 36) chk("scr_wrap_char1", tif.char1, rom[1]);
        end

        // Reload mid-fetch: song 1 then song 2
        fetch(1, 1'b0, 10, 2);
        tick();
        chk("reload_char1", tif.char1, owl[0]);
        chk("reload_char5", tif.char5, SP);

        // load coincident with frame_tick in DISPLAY
        fetch(0, 1'b1, 0, 0);
        tick();

        // Length 31 clamps to 24, period 28
        fill_song(3, 31);
        fetch(3, 1'b0, 0, 0);
        for (int t = 0; t < 60; t++) begin
            tick();
            if (t == 54) chk("clamp_gap_char1", tif.char1, SP);
            if (t == 56) chk("clamp_wrap_char1", tif.char1, rom[97]);
        end

        // Randomized titles, lengths and tick spacing
        for (int it = 0; it < 8; it++) begin
            int s;
            s = $urandom_range(0, 3);
            if (s == 3) fill_song(3, $urandom_range(0, 31));
            fetch(s, 1'($urandom_range(0, 1)), 0, 0);
            for (int t = 0; t < int'($urandom_range(1, 40)); t++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc();
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
